tick_timer_bank: RTL and testbench
==================================

Name: tick_timer_bank

Overview:
- Parametrised successor to the fixed 1 ms tick divider.
- A shared prescaler produces a base tick every CLK_DIV clocks. NCH independent channels count that tick down from a programmable period.
- Each channel runs periodic or one-shot and emits a one-clock pulse on expiry.
- Sits between the board clock and game logic (animation frame timing, move timers, debounce windows).

Parameters:
- CLK_DIV, 50000, clocks per base tick (1 ms at 50 MHz); legal range >= 2.
- CNT_W, 16, channel period/counter width.
- NCH, 4, number of channels.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- tick_en  in  1  global prescaler enable.
- base_tick  out  1  one-clock base tick strobe.
- ch_load  in  NCH  per-channel load strobe.
- ch_period  in  NCH*CNT_W  channel i period in base ticks, bits [i*CNT_W +: CNT_W].
- ch_mode  in  NCH  per channel: 0 = periodic, 1 = one-shot; sampled on load.
- ch_stop  in  NCH  per-channel stop strobe.
- ch_pulse  out  NCH  one-clock expiry pulse.
- ch_busy  out  NCH  channel armed and counting.
- ch_count  out  NCH*CNT_W  remaining base ticks per channel.

Behaviour:
- Reset (async, active-high) clears:
  - prescaler counter, base_tick, all channel counters, latched periods, latched modes, ch_pulse, ch_busy, ch_count.
  - No tick or pulse is asserted out of reset.
- Prescaler: counts 0..CLK_DIV-1.
  - While tick_en = 1: on the edge where count == CLK_DIV-1, count <= 0 and base_tick <= 1; on all other edges count++ and base_tick <= 0.
  - While tick_en = 0: count holds and base_tick <= 0.
  - With tick_en held high from reset release, base_tick is high on exactly one of every CLK_DIV cycles. The first assertion is after the CLK_DIV-th rising edge.
- Channel i, per-edge priority: load > stop > tick.
  - Load, ch_load[i] = 1 with period P:
    - P != 0: period_q <= P, mode_q <= ch_mode[i], count <= P, busy <= 1.
    - P == 0: busy <= 0, count <= 0.
    - A base_tick in the same cycle is ignored by this channel.
    - Reloading a busy channel restarts it.
  - Stop, ch_stop[i] = 1 without load: busy <= 0, count <= 0, no pulse. Stop on an idle channel has no effect.
  - Tick, base_tick = 1 with busy = 1:
    - count > 1: count <= count-1.
    - count == 1: ch_pulse[i] <= 1 for one clock. Then:
      - periodic: count <= period_q, busy stays 1.
      - one-shot: count <= 0, busy <= 0.
  - ch_pulse is otherwise 0. It is registered: high in the cycle after the base_tick that expired the channel.
- Timing guarantees:
  - First pulse after load comes after P base ticks.
  - Periodic pulse spacing is exactly P*CLK_DIV clocks while tick_en stays high.
- Arithmetic:
  - Counters are unsigned CNT_W.
  - Maximum period is 2^CNT_W - 1.
  - No wrap-around: count never decrements below 1 while busy.
- Independence:
  - Channels are fully independent; simultaneous loads, stops and expiries on different channels are all honoured in the same cycle.
  - tick_en low freezes all channels; they resume where they left off.
- ch_busy and ch_count are direct register outputs.
- Reset mid-count aborts every channel immediately. No pulse may be emitted on the first edge after release.

Test Plan:
- CLK_DIV=4, tick_en=1 from reset release -> base_tick high on edges 4, 8, 12…; never high during or immediately after reset.
- CLK_DIV=4, load ch0 P=3 periodic -> ch_pulse[0] every 12 clocks; ch_count[0] sequence 3, 2, 1, 3…; ch_busy[0] stays 1.
- Load ch1 P=2 one-shot -> exactly one pulse after 2 base ticks, then ch_busy[1]=0, ch_count[1]=0; further ticks produce nothing.
- Corner strobes:
  - load coincident with base_tick -> count = P, not P-1;
  - load and stop together -> load wins;
  - ch_stop at count=1 before the tick -> no pulse;
  - load with P=0 -> idle.
- tick_en dropped mid-count for 10 clocks -> base_tick and channel counts frozen; pulse timing shifted by exactly 10 clocks.
- Reset asserted mid-operation with ch0–ch3 busy -> all outputs 0 asynchronously; no pulses after release until reload.

Source files
------------

// File: rtl/tick_timer_bank.sv
// rtl/tick_timer_bank.sv - shared prescaler feeding NCH periodic/one-shot down-counting channels
module tick_timer_bank #(
    parameter int CLK_DIV = 50000,
    parameter int CNT_W   = 16,
    parameter int NCH     = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tick_en,
    output logic                 base_tick,
    input  logic [NCH-1:0]       ch_load,
    input  logic [NCH*CNT_W-1:0] ch_period,
    input  logic [NCH-1:0]       ch_mode,
    input  logic [NCH-1:0]       ch_stop,
    output logic [NCH-1:0]       ch_pulse,
    output logic [NCH-1:0]       ch_busy,
    output logic [NCH*CNT_W-1:0] ch_count
);

    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0]    PRESC_MAX = PW'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic [PW-1:0] presc_q, presc_d;
    logic          base_tick_q, base_tick_d;

    logic [NCH-1:0][CNT_W-1:0] count_q, count_d;
    logic [NCH-1:0][CNT_W-1:0] period_q, period_d;
    logic [NCH-1:0]            mode_q, mode_d;
    logic [NCH-1:0]            busy_q, busy_d;
    logic [NCH-1:0]            pulse_q, pulse_d;

    // Prescaler: wraps at CLK_DIV-1 and strobes base_tick for one clock; freezes when disabled.
    always_comb begin
        presc_d     = presc_q;
        base_tick_d = 1'b0;
        if (tick_en) begin
            if (presc_q == PRESC_MAX) begin
                presc_d     = '0;
                base_tick_d = 1'b1;
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end
    end

    // Channel next-state: load beats stop beats tick; the registered base_tick drives the countdown.
    always_comb begin
        count_d  = count_q;
        period_d = period_q;
        mode_d   = mode_q;
        busy_d   = busy_q;
        pulse_d  = '0;
        for (int i = 0; i < NCH; i++) begin
            if (ch_load[i]) begin
                if (ch_period[i*CNT_W +: CNT_W] != '0) begin
                    period_d[i] = ch_period[i*CNT_W +: CNT_W];
                    mode_d[i]   = ch_mode[i];
                    count_d[i]  = ch_period[i*CNT_W +: CNT_W];
                    busy_d[i]   = 1'b1;
                end else begin
                    count_d[i] = '0;
                    busy_d[i]  = 1'b0;
                end
            end else if (ch_stop[i]) begin
                count_d[i] = '0;
                busy_d[i]  = 1'b0;
            end else if (base_tick_q && busy_q[i]) begin
                if (count_q[i] > CNT_ONE) begin
                    count_d[i] = count_q[i] - CNT_ONE;
                end else begin
                    pulse_d[i] = 1'b1;
                    if (mode_q[i]) begin
                        count_d[i] = '0;
                        busy_d[i]  = 1'b0;
                    end else begin
                        count_d[i] = period_q[i];
                    end
                end
            end
        end
    end

    // State registers; reset aborts everything immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q     <= '0;
            base_tick_q <= 1'b0;
            count_q     <= '0;
            period_q    <= '0;
            mode_q      <= '0;
            busy_q      <= '0;
            pulse_q     <= '0;
        end else begin
            presc_q     <= presc_d;
            base_tick_q <= base_tick_d;
            count_q     <= count_d;
            period_q    <= period_d;
            mode_q      <= mode_d;
            busy_q      <= busy_d;
            pulse_q     <= pulse_d;
        end
    end

    assign base_tick = base_tick_q;
    assign ch_pulse  = pulse_q;
    assign ch_busy   = busy_q;
    assign ch_count  = count_q;

endmodule

// File: tb/tb_tick_timer_bank.sv
// tb/tb_tick_timer_bank.sv - directed bench for tick_timer_bank
module tb_tick_timer_bank;

    localparam int CLK_DIV = 4;
    localparam int CNT_W   = 16;
    localparam int NCH     = 4;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 tick_en;
    logic                 base_tick;
    logic [NCH-1:0]       ch_load;
    logic [NCH*CNT_W-1:0] ch_period;
    logic [NCH-1:0]       ch_mode;
    logic [NCH-1:0]       ch_stop;
    logic [NCH-1:0]       ch_pulse;
    logic [NCH-1:0]       ch_busy;
    logic [NCH*CNT_W-1:0] ch_count;

    int total = 0;
    int bad   = 0;
    int e     = 0;

    always #5 clk = ~clk;

    tick_timer_bank #(.CLK_DIV(CLK_DIV), .CNT_W(CNT_W), .NCH(NCH)) dut (
        .clk       (clk),
        .reset     (reset),
        .tick_en   (tick_en),
        .base_tick (base_tick),
        .ch_load   (ch_load),
        .ch_period (ch_period),
        .ch_mode   (ch_mode),
        .ch_stop   (ch_stop),
        .ch_pulse  (ch_pulse),
        .ch_busy   (ch_busy),
        .ch_count  (ch_count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (edge %0d)", tag, obs, exp, e);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        e++;
    endtask

    function automatic logic [CNT_W-1:0] cnt(input int i);
        return ch_count[i*CNT_W +: CNT_W];
    endfunction

    initial begin
        reset     = 1'b1;
        tick_en   = 1'b1;
        ch_load   = '0;
        ch_period = '0;
        ch_mode   = '0;
        ch_stop   = '0;

        // held in reset: nothing may tick
        #2;
        chk("rst_base_tick", base_tick, 0);
        chk("rst_busy", ch_busy, 0);
        chk("rst_count", ch_count, 0);
        chk("rst_pulse", ch_pulse, 0);
        repeat (3) begin
            step();
            chk("rst_hold_tick", base_tick, 0);
        end

        // release; edges are numbered from here
        reset = 1'b0;
        e = 0;
        for (int k = 1; k <= 12; k++) begin
            step();
            chk("base_tick_seq", base_tick, (e % 4 == 0));
            if (k == 1) chk("first_edge_pulse", ch_pulse, 0);
        end

        // ch0 periodic P=3, load lands on the edge consuming a base_tick
        ch_load = 4'b0001;
        ch_period[0*CNT_W +: CNT_W] = 16'd3;
        ch_mode = 4'b0000;
        step();
        ch_load = '0;
        for (int k = 0; k < 25; k++) begin
            if (k > 0) step();
            chk("ch0_count", cnt(0), 3 - ((e - 13) / 4) % 3);
            chk("ch0_pulse", ch_pulse[0], (e > 13) && ((e - 13) % 12 == 0));
            chk("ch0_busy", ch_busy[0], 1);
        end

        // ch1 one-shot P=2
        ch_load = 4'b0010;
        ch_period[1*CNT_W +: CNT_W] = 16'd2;
        ch_mode = 4'b0010;
        step();
        ch_load = '0;
        for (int k = 0; k < 23; k++) begin
            if (k > 0) step();
            chk("ch1_pulse", ch_pulse[1], (e == 45));
            chk("ch1_busy", ch_busy[1], (e < 45));
            chk("ch1_count", cnt(1), (e < 41) ? 2 : ((e < 45) ? 1 : 0));
        end

        // load and stop together: load wins
        ch_load = 4'b0100;
        ch_stop = 4'b0100;
        ch_period[2*CNT_W +: CNT_W] = 16'd5;
        step();
        ch_load = '0;
        ch_stop = '0;
        chk("ld_stop_busy", ch_busy[2], 1);
        chk("ld_stop_count", cnt(2), 5);

        // load with P=0 idles the channel
        ch_load = 4'b0100;
        ch_period[2*CNT_W +: CNT_W] = 16'd0;
        step();
        ch_load = '0;
        chk("p0_busy", ch_busy[2], 0);
        chk("p0_count", cnt(2), 0);

        // stop at count=1 before the tick: no pulse
        ch_load = 4'b1000;
        ch_period[3*CNT_W +: CNT_W] = 16'd1;
        step();
        ch_load = '0;
        chk("ch3_load_count", cnt(3), 1);
        chk("ch3_load_busy", ch_busy[3], 1);
        ch_stop = 4'b1000;
        step();
        ch_stop = '0;
        chk("ch3_stop_busy", ch_busy[3], 0);
        chk("ch3_stop_count", cnt(3), 0);
        repeat (8) begin
            step();
            chk("ch3_no_pulse", ch_pulse[3], 0);
        end

        // tick_en freeze: reload ch0 P=2 just after a base_tick, freeze 10 clocks
        for (int k = 0; k < 4 && (e % 4 != 0); k++) step();
        chk("align_tick", base_tick, 1);
        ch_load = 4'b0001;
        ch_period[0*CNT_W +: CNT_W] = 16'd2;
        ch_mode = 4'b0000;
        step();
        ch_load = '0;
        for (int r = 1; r <= 20; r++) begin
            if (r == 6)  tick_en = 1'b0;
            if (r == 16) tick_en = 1'b1;
            step();
            chk("frz_pulse", ch_pulse[0], (r == 18));
            chk("frz_tick", base_tick, (r == 3) || (r == 17));
            chk("frz_count", cnt(0), (r < 4) ? 2 : ((r < 18) ? 1 : 2));
        end

        // reset mid-operation with every channel busy
        ch_load = 4'b1111;
        ch_mode = 4'b0000;
        for (int i = 0; i < NCH; i++) ch_period[i*CNT_W +: CNT_W] = 16'd1;
        step();
        ch_load = '0;
        chk("all_busy", ch_busy, 4'hF);
        step();
        step();
        #2;
        reset = 1'b1;
        #1;
        chk("async_busy", ch_busy, 0);
        chk("async_count", ch_count, 0);
        chk("async_tick", base_tick, 0);
        chk("async_pulse", ch_pulse, 0);
        step();
        step();
        reset = 1'b0;
        repeat (20) begin
            step();
            chk("post_rst_pulse", ch_pulse, 0);
            chk("post_rst_busy", ch_busy, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
